// File: rtl/sprite_defs_pkg.sv
// Shared definitions for the sprite fetch scheduler: ROM row width, default
// fetch-window bounds and the sequencer state encoding.
package sprite_defs;

  localparam int ROW_ADDR_W           = 4;
  localparam int DEFAULT_WINDOW_START = 256;
  localparam int DEFAULT_WINDOW_END   = 308;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } sched_state_t;

  // Next index after v in a ring of n entries.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
    if (int'(v) + 1 >= n) begin
      return 3'd0;
    end
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: returns the first set request bit
// found searching upward from ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   index
);

  always_comb begin
    int tgt;
    tgt   = 0;
    valid = 1'b0;
    index = 3'd0;
    for (int off = 0; off < N; off++) begin
      tgt = int'(ptr) + off;
      if (tgt >= N) begin
        tgt = tgt - N;
      end
      for (int i = 0; i < N; i++) begin
        if (!valid && tgt == i && req[i]) begin
          valid = 1'b1;
          index = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Time-shares the sprite bitmap ROM among renderers during horizontal blank:
// one ARB cycle per grant, SLOT_CYCLES load cycles, at most one grant per renderer per line.
module sprite_fetch_scheduler
  import sprite_defs::*;
#(
  parameter int NUM_SPRITES  = 4,
  parameter int SLOT_CYCLES  = 4,
  parameter int WINDOW_START = DEFAULT_WINDOW_START,
  parameter int WINDOW_END   = DEFAULT_WINDOW_END
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [8:0]                        hpos,
  input  logic [NUM_SPRITES-1:0]            fetch_req,
  input  logic [ROW_ADDR_W*NUM_SPRITES-1:0] rom_addr_in,
  output logic [NUM_SPRITES-1:0]            load,
  output logic [ROW_ADDR_W-1:0]             rom_yofs,
  output logic [2:0]                        grant_id,
  output logic                              busy,
  output logic                              line_overrun
);

  sched_state_t state_reg, state_next;
  logic [2:0] grant_id_reg, grant_id_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [NUM_SPRITES-1:0] served_reg, served_next;
  logic overrun_reg, overrun_next;
  logic [ROW_ADDR_W-1:0] yofs_hold_reg, yofs_hold_next;

  logic [ROW_ADDR_W-1:0] row_addr [NUM_SPRITES];
  logic [ROW_ADDR_W-1:0] grant_row;
  logic [NUM_SPRITES-1:0] candidates;
  logic pick_valid;
  logic [2:0] pick_index;
  logic [9:0] hpos_ext;
  logic window_ok;

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_lane
      assign row_addr[gi] = rom_addr_in[ROW_ADDR_W*gi +: ROW_ADDR_W];
      assign load[gi]     = (state_reg == ST_GRANT) && (grant_id_reg == 3'(gi));
    end
  endgenerate

  always_comb begin
    grant_row = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (grant_id_reg == 3'(i)) begin
        grant_row = row_addr[i];
      end
    end
  end

  assign candidates = fetch_req & ~served_reg;

  rr_priority_pick #(
    .N(NUM_SPRITES)
  ) u_pick (
    .req  (candidates),
    .ptr  (ptr_reg),
    .valid(pick_valid),
    .index(pick_index)
  );

  // Zero-extended so hpos near 511 plus a slot cannot wrap past the window end.
  assign hpos_ext  = {1'b0, hpos};
  assign window_ok = (hpos_ext + 10'(SLOT_CYCLES)) <= 10'(WINDOW_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_id_reg  <= 3'd0;
      ptr_reg       <= 3'd0;
      cnt_reg       <= 4'd0;
      served_reg    <= '0;
      overrun_reg   <= 1'b0;
      yofs_hold_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_id_reg  <= grant_id_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      served_reg    <= served_next;
      overrun_reg   <= overrun_next;
      yofs_hold_reg <= yofs_hold_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_id_next  = grant_id_reg;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    served_next    = served_reg;
    overrun_next   = 1'b0;
    yofs_hold_next = yofs_hold_reg;
    case (state_reg)
      ST_IDLE: begin
        if (hpos == 9'(WINDOW_START)) begin
          served_next = '0;
          state_next  = ST_ARB;
        end
      end
      ST_ARB: begin
        if (pick_valid && window_ok) begin
          grant_id_next = pick_index;
          cnt_next      = 4'(SLOT_CYCLES - 1);
          state_next    = ST_GRANT;
        end else begin
          // Pending work left on the table closes the line with an overrun flag.
          overrun_next = |candidates;
          state_next   = ST_IDLE;
        end
      end
      ST_GRANT: begin
        yofs_hold_next = grant_row;
        if (cnt_reg == 4'd0) begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            if (grant_id_reg == 3'(i)) begin
              served_next[i] = 1'b1;
            end
          end
          ptr_next   = wrap_inc(grant_id_reg, NUM_SPRITES);
          state_next = ST_ARB;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rom_yofs     = (state_reg == ST_GRANT) ? grant_row : yofs_hold_reg;
  assign grant_id     = grant_id_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign line_overrun = overrun_reg;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Bench for sprite_fetch_scheduler: two instances (default and long-slot/short-window)
// checked every cycle against an hpos-timeline model, plus literal line checks.
module tb_sprite_fetch_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [8:0] hpos = 9'd0;
  logic [3:0] fetch_req = 4'd0;
  logic [15:0] rom_addr_in = 16'd0;

  logic [3:0] load_a, load_b;
  logic [3:0] yofs_a, yofs_b;
  logic [2:0] gid_a, gid_b;
  logic busy_a, busy_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  sprite_fetch_scheduler #(
    .NUM_SPRITES(4), .SLOT_CYCLES(4), .WINDOW_START(256), .WINDOW_END(308)
  ) dut_a (
    .clk(clk), .reset(reset), .hpos(hpos), .fetch_req(fetch_req),
    .rom_addr_in(rom_addr_in), .load(load_a), .rom_yofs(yofs_a),
    .grant_id(gid_a), .busy(busy_a), .line_overrun(ovr_a)
  );

  sprite_fetch_scheduler #(
    .NUM_SPRITES(4), .SLOT_CYCLES(15), .WINDOW_START(256), .WINDOW_END(290)
  ) dut_b (
    .clk(clk), .reset(reset), .hpos(hpos), .fetch_req(fetch_req),
    .rom_addr_in(rom_addr_in), .load(load_b), .rom_yofs(yofs_b),
    .grant_id(gid_b), .busy(busy_b), .line_overrun(ovr_b)
  );

  int checks = 0;
  int failures = 0;
  int line_no = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: each instance is described as a timeline of hpos values
  // (next arbitration hpos, current slot range, pending overrun hpos).
  int s_cfg[2] = '{4, 15};
  int e_cfg[2] = '{308, 290};
  int m_arb[2], m_lo[2], m_hi[2], m_gid[2], m_ptr[2], m_served[2], m_last[2], m_ovr[2];
  bit m_on = 1'b0;

  int tr_load[2][512];
  int tr_yofs[2][512];
  int tr_gid[2][512];
  int tr_busy[2][512];
  int tr_ovr[2][512];

  function automatic int addr_of(input logic [15:0] v, input int i);
    return int'((v >> (4 * i)) & 16'hF);
  endfunction

  task automatic model_step(input int c);
    int h, cands, win, idx;
    bit in_slot;
    h = int'(hpos);
    if (reset) begin
      m_arb[c] = -10; m_lo[c] = -10; m_hi[c] = -10; m_ovr[c] = -10;
      m_gid[c] = 0; m_ptr[c] = 0; m_served[c] = 0; m_last[c] = 0;
      m_on = 1'b1;
      return;
    end
    in_slot = (h >= m_lo[c]) && (h <= m_hi[c]);
    if (h == m_ovr[c]) m_ovr[c] = -10;
    if (in_slot) m_last[c] = addr_of(rom_addr_in, m_gid[c]);
    if (in_slot && h == m_hi[c]) begin
      m_served[c] = m_served[c] | (1 << m_gid[c]);
      m_ptr[c] = (m_gid[c] + 1) % N;
      m_lo[c] = -10;
      m_hi[c] = -10;
    end
    if (h == m_arb[c]) begin
      cands = int'(fetch_req) & ~m_served[c] & 'hF;
      win = -1;
      for (int off = 0; off < N; off++) begin
        idx = (m_ptr[c] + off) % N;
        if (win < 0 && ((cands >> idx) & 1) == 1) win = idx;
      end
      if (win >= 0 && h + s_cfg[c] <= e_cfg[c]) begin
        m_gid[c] = win;
        m_lo[c] = h + 1;
        m_hi[c] = h + s_cfg[c];
        m_arb[c] = h + s_cfg[c] + 1;
      end else begin
        m_arb[c] = -10;
        if (cands != 0) m_ovr[c] = h + 1;
      end
    end else if (m_arb[c] < 0 && !in_slot && h == 256) begin
      m_served[c] = 0;
      m_arb[c] = 257;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int c = 0; c < 2; c++) model_step(c);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        for (int c = 0; c < 2; c++) begin
          int h, e_load, e_yofs, a_load, a_yofs, a_gid, a_busy, a_ovr;
          bit in_slot;
          h = int'(hpos);
          in_slot = (h >= m_lo[c]) && (h <= m_hi[c]);
          e_load = in_slot ? (1 << m_gid[c]) : 0;
          e_yofs = in_slot ? addr_of(rom_addr_in, m_gid[c]) : m_last[c];
          a_load = int'(c == 0 ? load_a : load_b);
          a_yofs = int'(c == 0 ? yofs_a : yofs_b);
          a_gid  = int'(c == 0 ? gid_a : gid_b);
          a_busy = int'(c == 0 ? busy_a : busy_b);
          a_ovr  = int'(c == 0 ? ovr_a : ovr_b);
          chk($sformatf("load%0d@h%0d", c, h), a_load, e_load);
          chk($sformatf("yofs%0d@h%0d", c, h), a_yofs, e_yofs);
          chk($sformatf("gid%0d@h%0d", c, h), a_gid, m_gid[c]);
          chk($sformatf("busy%0d@h%0d", c, h), a_busy, int'(in_slot || h == m_arb[c]));
          chk($sformatf("ovr%0d@h%0d", c, h), a_ovr, int'(h == m_ovr[c]));
          tr_load[c][h] = a_load;
          tr_yofs[c][h] = a_yofs;
          tr_gid[c][h]  = a_gid;
          tr_busy[c][h] = a_busy;
          tr_ovr[c][h]  = a_ovr;
        end
      end
    end
  end

  task automatic run_line(input logic [3:0] req, input logic [15:0] addr,
                          input bit rnd, input int reset_h);
    logic [3:0] r;
    r = req;
    for (int h = 250; h <= 315; h++) begin
      @(posedge clk);
      #1;
      hpos = 9'(h);
      reset = (h == reset_h);
      if (rnd) begin
        if ($urandom_range(7) == 0) r = 4'($urandom);
        rom_addr_in = 16'($urandom);
      end else begin
        rom_addr_in = addr;
      end
      fetch_req = r;
    end
    @(negedge clk);
    line_no++;
    $display("line %0d req=%b rnd=%0d reset_h=%0d", line_no, req, rnd, reset_h);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    hpos = 9'd0;
    fetch_req = 4'd0;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int count_line(input int c, input bit ovr);
    int n;
    n = 0;
    for (int h = 250; h <= 315; h++) begin
      if (ovr) n += tr_ovr[c][h];
      else if (tr_load[c][h] != 0) n++;
    end
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    @(negedge clk);
    chk("rst_load", int'(load_a), 0);
    chk("rst_yofs", int'(yofs_a), 0);
    chk("rst_gid", int'(gid_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_ovr", int'(ovr_b), 0);

    // No requests: one ARB cycle then idle.
    run_line(4'b0000, 16'h1234, 1'b0, -1);
    chk("noreq_busy257", tr_busy[0][257], 1);
    chk("noreq_busy258", tr_busy[0][258], 0);
    chk("noreq_loads", count_line(0, 1'b0), 0);
    chk("noreq_ovr", count_line(0, 1'b1), 0);

    // All request from ptr 0; instance b overruns after two long slots.
    run_line(4'b1111, 16'h4321, 1'b0, -1);
    chk("all_258", tr_load[0][258], 1);
    chk("all_262", tr_load[0][262], 0);
    chk("all_263", tr_load[0][263], 2);
    chk("all_yofs263", tr_yofs[0][263], 2);
    chk("all_268", tr_load[0][268], 4);
    chk("all_273", tr_load[0][273], 8);
    chk("all_276", tr_load[0][276], 8);
    chk("all_busy277", tr_busy[0][277], 1);
    chk("all_busy278", tr_busy[0][278], 0);
    chk("ovrun_258", tr_load[1][258], 1);
    chk("ovrun_272", tr_load[1][272], 1);
    chk("ovrun_273", tr_load[1][273], 0);
    chk("ovrun_274", tr_load[1][274], 2);
    chk("ovrun_288", tr_load[1][288], 2);
    chk("ovrun_289", tr_load[1][289], 0);
    chk("ovrun_pulse290", tr_ovr[1][290], 1);
    chk("ovrun_pulses", count_line(1, 1'b1), 1);

    // Only 0 and 3 request: 0 then 3 (b has ptr 2, so 3 then 0).
    run_line(4'b1001, 16'h4321, 1'b0, -1);
    chk("pair_258", tr_load[0][258], 1);
    chk("pair_263", tr_load[0][263], 8);
    chk("pairb_258", tr_load[1][258], 8);
    chk("pairb_274", tr_load[1][274], 1);

    // Single requester 2 with row address 9.
    run_line(4'b0100, 16'h5971, 1'b0, -1);
    chk("single_258", tr_load[0][258], 4);
    chk("single_261", tr_load[0][261], 4);
    chk("single_262", tr_load[0][262], 0);
    chk("single_yofs258", tr_yofs[0][258], 9);
    chk("single_gid261", tr_gid[0][261], 2);
    chk("single_busy263", tr_busy[0][263], 0);
    chk("single_hold270", tr_yofs[0][270], 9);
    chk("single_ovr", count_line(0, 1'b1), 0);

    // Rotation across lines.
    do_reset();
    run_line(4'b0011, 16'h4321, 1'b0, -1);
    chk("rot1_258", tr_load[0][258], 1);
    chk("rot1_263", tr_load[0][263], 2);
    run_line(4'b1011, 16'h4321, 1'b0, -1);
    chk("rot2_258", tr_load[0][258], 8);
    chk("rot2_263", tr_load[0][263], 1);
    chk("rot2_268", tr_load[0][268], 2);

    // Reset in the middle of grant 0.
    do_reset();
    run_line(4'b1111, 16'h4321, 1'b0, 260);
    chk("rstmid_260", tr_load[0][260], 1);
    chk("rstmid_261", tr_load[0][261], 0);
    chk("rstmid_busy261", tr_busy[0][261], 0);
    run_line(4'b1111, 16'h4321, 1'b0, -1);
    chk("rstmid_next258", tr_load[0][258], 1);

    for (int i = 0; i < 40; i++) begin
      int rh;
      rh = ($urandom_range(7) == 0) ? int'($urandom_range(250, 315)) : -1;
      run_line(4'($urandom), 16'($urandom), 1'b1, rh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_scheduler.md
# sprite_fetch_scheduler

Time-shares the single car/sprite bitmap ROM among up to `NUM_SPRITES` sprite renderers during each horizontal-blank fetch window. It replaces the hard-wired `hpos` decode of per-renderer `load` strobes in the game top level with a request/grant sequencer. The sequencer has rotating priority, grants at most once per renderer per line, and flags lines on which a pending fetch could not be served. It sits between the sync generator's `hpos` and the renderers' `load`/`rom_addr` ports, and drives the shared ROM's `yofs` input.

## Interface
- `NUM_SPRITES`, default 4: number of renderers; range 2–8.
- `SLOT_CYCLES`, default 4: cycles `load` is held per grant; range 1–15.
- `WINDOW_START`, default 256: first `hpos` of the fetch window.
- `WINDOW_END`, default 308: last `hpos` of the fetch window, inclusive.
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `hpos` in 9: horizontal position from the sync generator.
- `fetch_req` in NUM_SPRITES: renderer i has a row fetch pending. Level signal, sampled only in ARB.
- `rom_addr_in` in 4*NUM_SPRITES: flattened per-renderer ROM row addresses; renderer i occupies bits [4i+3:4i].
- `load` out NUM_SPRITES: one-hot or zero; wired to the renderers' `load` inputs.
- `rom_yofs` out 4: address to the shared bitmap ROM.
- `grant_id` out 3: index of the current or last grantee.
- `busy` out 1: high in ARB or GRANT.
- `line_overrun` out 1: one-cycle pulse on the window-close cycle when a request was left unserved.

## Operation
- The FSM has three states: IDLE, ARB and GRANT.
- **IDLE**
  - `load` is 0.
  - When `hpos == WINDOW_START`: clear the `served` mask, go to ARB.
- **ARB**, one cycle.
  - Candidates are `fetch_req & ~served`.
  - The winner is the first candidate searching upward from `ptr`, wrapping modulo NUM_SPRITES.
  - If there is a winner and `hpos + SLOT_CYCLES <= WINDOW_END`: latch `grant_id`, load `cnt = SLOT_CYCLES-1`, go to GRANT.
  - Otherwise (no candidate, or too little window left): go to IDLE. Pulse `line_overrun` if candidates were non-zero.
- **GRANT**
  - `load[grant_id]` is 1.
  - `rom_yofs = rom_addr_in[grant_id]`, combinational from the registered `grant_id`.
  - `cnt` decrements each cycle.
  - When `cnt == 0`: set `served[grant_id]`, set `ptr = (grant_id+1) mod NUM_SPRITES`, go to ARB.
- `ptr` persists across lines and frames, so starvation rotates.
- In IDLE, `rom_yofs` holds its last value.
- Every grant starts and ends inside the window. A GRANT is never truncated, including when `hpos` passes WINDOW_END.
- `fetch_req` deasserting during GRANT has no effect; the slot completes.
- Widths:
  - The window comparison uses `hpos` zero-extended to 10 bits, so there is no wrap error.
  - `cnt` is 4 bits.
  - `ptr` and `grant_id` are 3 bits.

## Timing
- Reset values:
  - state IDLE.
  - `load=0`, `rom_yofs=0`, `grant_id=0`, `busy=0`, `line_overrun=0`.
  - `ptr=0`, `served=0`, `cnt=0`.
- Reset mid-GRANT: `load` is 0 on the cycle after the reset edge, and no `served` bit is set.
- Latency:
  - `hpos == WINDOW_START` seen in IDLE → ARB on the next cycle.
  - ARB → first `load` cycle on the next cycle.
- Each grant occupies `SLOT_CYCLES + 1` cycles (ARB plus GRANT).
- With the defaults, 4 grants take 20 cycles: ARB at hpos 257, grants at 258–261, 263–266, 268–271, 273–276, final ARB at 277.
- The `rom_addr_in[i]` to `rom_yofs` path is purely combinational. The renderer sees `rom_bits` in the same cycle.
- `line_overrun` is registered and asserts in the cycle after the closing ARB.

## Structure
- Shared package/header (`sprite_defs`):
  - ROM row address width (4).
  - Default window bounds (256/308).
  - FSM state encodings.
- One natural sub-module: `rr_priority_pick` (combinational), taking `req`, `ptr` and returning `valid`, `index`. It is reusable for other shared-resource arbiters.

## Test plan
- **Single requester:** `fetch_req=4'b0100`, `rom_addr_in[2]=9` → `load=4'b0100` for hpos 258–261, `rom_yofs=9` there, `grant_id=2`, then IDLE at 263 with no overrun.
- **All request, ptr=0:** `fetch_req=4'b1111` → grants in order 0,1,2,3 at hpos 258/263/268/273; `ptr=0` afterwards. Next line with only req[0],req[3] → 0 then 3.
- **Rotation:**
  - Line 1: `fetch_req=4'b0011` → grants 0,1; `ptr=2`.
  - Line 2: `fetch_req=4'b1011` → order 3,0,1.
- **Overrun:** `SLOT_CYCLES=15`, `WINDOW_END=290`, all four request → two grants (258–272, 274–288). `line_overrun` pulses once; renderers 2,3 unserved.
- **Reset mid-grant:** assert `reset` at hpos 260 during grant 0 → `load=0` next cycle, `ptr=0`. Next line, renderer 0 is granted first.
- **No requests:** `fetch_req=0` → ARB at 257, IDLE at 258, `load` never asserted, no overrun.
